// File: rtl/decode_stage.sv
// Registered Thumb-16 decode stage with a 2-entry skid buffer toward execute.
// DECODE_BCOND_EN enables conditional-branch (BCC) decode; otherwise 1101 patterns are undefined.
module decode_stage #(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 4,
  parameter int UOP_W  = 5,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instruction,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [UOP_W-1:0]  uop,
  output logic              num_to_rhs,
  output logic [DATA_W-1:0] num,
  output logic [SEL_W-1:0]  sel_p0,
  output logic [SEL_W-1:0]  sel_p1,
  output logic [SEL_W-1:0]  sel_in,
  output logic [3:0]        cond,
  output logic              explose,
  output logic [CNT_W-1:0]  illegal_count
);

  localparam logic [UOP_W-1:0] U_ADD = UOP_W'(1);
  localparam logic [UOP_W-1:0] U_SUB = UOP_W'(2);
  localparam logic [UOP_W-1:0] U_CMP = UOP_W'(3);
  localparam logic [UOP_W-1:0] U_EOR = UOP_W'(4);
  localparam logic [UOP_W-1:0] U_LSL = UOP_W'(5);
  localparam logic [UOP_W-1:0] U_MOV = UOP_W'(6);
  localparam logic [UOP_W-1:0] U_LDR = UOP_W'(7);
  localparam logic [UOP_W-1:0] U_STR = UOP_W'(8);
  localparam logic [UOP_W-1:0] U_B   = UOP_W'(9);
`ifdef DECODE_BCOND_EN
  localparam logic [UOP_W-1:0] U_BCC = UOP_W'(10);
`endif

  typedef struct packed {
    logic [UOP_W-1:0]  uop;
    logic              rhs;
    logic [DATA_W-1:0] num;
    logic [SEL_W-1:0]  p0;
    logic [SEL_W-1:0]  p1;
    logic [SEL_W-1:0]  wb;
    logic [3:0]        cond;
    logic              expl;
  } dec_t;

  dec_t             dec_d, main_q, skid_q;
  logic             main_vld_q, skid_vld_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_fire, out_fire, load_main;

  always_comb begin
    dec_d = '0;
    casez (instruction)
      16'b00000???????????: begin
        dec_d.p0 = SEL_W'(instruction[5:3]);
        dec_d.wb = SEL_W'(instruction[2:0]);
        if (instruction[10:6] != 5'd0) begin
          dec_d.uop = U_LSL;
          dec_d.num = DATA_W'(instruction[10:6]);
          dec_d.rhs = 1'b1;
        end else begin
          dec_d.uop = U_MOV;
        end
      end
      16'b00011???????????: begin
        dec_d.uop = instruction[9] ? U_SUB : U_ADD;
        dec_d.p0  = SEL_W'(instruction[5:3]);
        dec_d.wb  = SEL_W'(instruction[2:0]);
        if (instruction[10]) begin
          dec_d.num = DATA_W'(instruction[8:6]);
          dec_d.rhs = 1'b1;
        end else begin
          dec_d.p1 = SEL_W'(instruction[8:6]);
        end
      end
      16'b001?????????????: begin
        case (instruction[12:11])
          2'b00:   dec_d.uop = U_MOV;
          2'b01:   dec_d.uop = U_CMP;
          2'b10:   dec_d.uop = U_ADD;
          default: dec_d.uop = U_SUB;
        endcase
        dec_d.num = DATA_W'(instruction[7:0]);
        dec_d.rhs = 1'b1;
        if (instruction[12:11] != 2'b00) dec_d.p0 = SEL_W'(instruction[10:8]);
        if (instruction[12:11] != 2'b01) dec_d.wb = SEL_W'(instruction[10:8]);
      end
      16'b0100000001??????: begin
        dec_d.uop = U_EOR;
        dec_d.p0  = SEL_W'(instruction[2:0]);
        dec_d.p1  = SEL_W'(instruction[5:3]);
        dec_d.wb  = SEL_W'(instruction[2:0]);
      end
      16'b0110????????????: begin
        // imm5 is a word index; execute does the scaling
        dec_d.num = DATA_W'(instruction[10:6]);
        dec_d.rhs = 1'b1;
        dec_d.p0  = SEL_W'(instruction[5:3]);
        if (instruction[11]) begin
          dec_d.uop = U_LDR;
          dec_d.wb  = SEL_W'(instruction[2:0]);
        end else begin
          dec_d.uop = U_STR;
          dec_d.p1  = SEL_W'(instruction[2:0]);
        end
      end
      16'b11100???????????: begin
        dec_d.uop = U_B;
        dec_d.num = {{(DATA_W-11){instruction[10]}}, instruction[10:0]};
        dec_d.rhs = 1'b1;
      end
      16'b1101????????????: begin
`ifdef DECODE_BCOND_EN
        if (instruction[11:8] <= 4'b1101) begin
          dec_d.uop  = U_BCC;
          dec_d.cond = instruction[11:8];
          dec_d.num  = {{(DATA_W-8){instruction[7]}}, instruction[7:0]};
          dec_d.rhs  = 1'b1;
        end else begin
          dec_d.expl = 1'b1;
        end
`else
        dec_d.expl = 1'b1;
`endif
      end
      default: dec_d.expl = 1'b1;
    endcase
  end

  assign in_fire   = in_valid & ~skid_vld_q;
  assign out_fire  = main_vld_q & out_ready;
  assign load_main = ~main_vld_q | out_fire;

  // Skid only fills when main is held; it always drains into main first, keeping order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
      cnt_q      <= '0;
    end else if (flush) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      if (load_main) begin
        main_vld_q <= skid_vld_q | in_fire;
        skid_vld_q <= 1'b0;
        if (skid_vld_q)   main_q <= skid_q;
        else if (in_fire) main_q <= dec_d;
      end else if (in_fire) begin
        skid_vld_q <= 1'b1;
        skid_q     <= dec_d;
      end
      if (in_fire && dec_d.expl && !(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign in_ready      = ~skid_vld_q;
  assign out_valid     = main_vld_q;
  assign uop           = main_q.uop;
  assign num_to_rhs    = main_q.rhs;
  assign num           = main_q.num;
  assign sel_p0        = main_q.p0;
  assign sel_p1        = main_q.p1;
  assign sel_in        = main_q.wb;
  assign cond          = main_q.cond;
  assign explose       = main_q.expl;
  assign illegal_count = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: queue-based reference model plus directed literal checks.
module tb_decode_stage;
  logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] instruction;
  logic [4:0]  uop;
  logic        num_to_rhs, explose;
  logic [31:0] num;
  logic [3:0]  sel_p0, sel_p1, sel_in, cond;
  logic [7:0]  illegal_count;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready), .uop(uop),
    .num_to_rhs(num_to_rhs), .num(num), .sel_p0(sel_p0), .sel_p1(sel_p1), .sel_in(sel_in),
    .cond(cond), .explose(explose), .illegal_count(illegal_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DECODE_BCOND_EN
  localparam bit BCOND = 1'b1;
`else
  localparam bit BCOND = 1'b0;
`endif

  typedef struct {
    logic [4:0]  uop;
    logic        rhs;
    logic [31:0] num;
    logic [3:0]  p0, p1, wb, cond;
    logic        expl;
  } exp_t;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q[$];
  int   m_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference decode from the instruction-format table.
  function automatic exp_t ref_dec(input logic [15:0] i);
    exp_t e = '{default: 0};
    int   op = int'(i[12:11]);
    if (i[15:11] == 5'b00000) begin
      e.p0 = 4'(i[5:3]); e.wb = 4'(i[2:0]);
      if (i[10:6] != 0) begin e.uop = 5; e.num = 32'(i[10:6]); e.rhs = 1; end
      else e.uop = 6;
    end else if (i[15:11] == 5'b00011) begin
      e.uop = i[9] ? 5'd2 : 5'd1;
      e.p0 = 4'(i[5:3]); e.wb = 4'(i[2:0]);
      if (i[10]) begin e.num = 32'(i[8:6]); e.rhs = 1; end
      else e.p1 = 4'(i[8:6]);
    end else if (i[15:13] == 3'b001) begin
      case (op) 0: e.uop = 6; 1: e.uop = 3; 2: e.uop = 1; default: e.uop = 2; endcase
      e.num = 32'(i[7:0]); e.rhs = 1;
      if (op != 0) e.p0 = 4'(i[10:8]);
      if (op != 1) e.wb = 4'(i[10:8]);
    end else if (i[15:6] == 10'b0100000001) begin
      e.uop = 4; e.p0 = 4'(i[2:0]); e.p1 = 4'(i[5:3]); e.wb = 4'(i[2:0]);
    end else if (i[15:12] == 4'b0110) begin
      e.num = 32'(i[10:6]); e.rhs = 1; e.p0 = 4'(i[5:3]);
      if (i[11]) begin e.uop = 7; e.wb = 4'(i[2:0]); end
      else begin e.uop = 8; e.p1 = 4'(i[2:0]); end
    end else if (i[15:11] == 5'b11100) begin
      e.uop = 9; e.rhs = 1;
      e.num = i[10] ? 32'(i[10:0]) - 32'd2048 : 32'(i[10:0]);
    end else if (BCOND && i[15:12] == 4'b1101 && i[11:8] <= 4'd13) begin
      e.uop = 10; e.rhs = 1; e.cond = i[11:8];
      e.num = i[7] ? 32'(i[7:0]) - 32'd256 : 32'(i[7:0]);
    end else begin
      e.expl = 1;
    end
    return e;
  endfunction

  // Model: a FIFO of at most two decoded entries.
  always @(posedge clk or negedge rst_n) begin
    exp_t d;
    bit   rdy, inf, outf;
    if (!rst_n) begin
      q.delete();
      m_cnt = 0;
    end else begin
      rdy  = q.size() < 2;
      inf  = in_valid && rdy;
      outf = q.size() > 0 && out_ready;
      d    = ref_dec(instruction);
      if (flush) q.delete();
      else begin
        if (outf) void'(q.pop_front());
        if (inf) q.push_back(d);
        if (inf && d.expl && m_cnt < 255) m_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("out_valid", out_valid, q.size() > 0);
      chk("in_ready", in_ready, q.size() < 2);
      chk("illegal_count", illegal_count, m_cnt);
      if (q.size() > 0) begin
        e = q[0];
        chk("uop", uop, e.uop);
        chk("num_to_rhs", num_to_rhs, e.rhs);
        chk("num", num, e.num);
        chk("sel_p0", sel_p0, e.p0);
        chk("sel_p1", sel_p1, e.p1);
        chk("sel_in", sel_in, e.wb);
        chk("cond", cond, e.cond);
        chk("explose", explose, e.expl);
      end
    end
  end

  function automatic logic [15:0] rand_ins();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 8))
      0: rand_ins = {5'b00000, r[10:0]};
      1: rand_ins = {5'b00011, r[10:0]};
      2: rand_ins = {3'b001, r[12:0]};
      3: rand_ins = {10'b0100000001, r[5:0]};
      4: rand_ins = {4'b0110, r[11:0]};
      5: rand_ins = {5'b11100, r[10:0]};
      6: rand_ins = {4'b1101, r[11:0]};
      default: rand_ins = r;
    endcase
  endfunction

  task automatic send(input logic [15:0] ins);
    in_valid = 1'b1;
    instruction = ins;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instruction = '0;
    #23 rst_n = 1'b1;
    @(negedge clk);
    chk("reset out_valid", out_valid, 0);
    chk("reset in_ready", in_ready, 1);
    chk("reset illegal_count", illegal_count, 0);
    chk("reset uop", uop, 0);
    chk("reset num", num, 0);
    chk("reset sel_in", sel_in, 0);

    out_ready = 1'b1;
    send(16'h192E);
    chk("add out_valid", out_valid, 1);
    chk("add uop", uop, 1);
    chk("add sel_in", sel_in, 6);
    chk("add num_to_rhs", num_to_rhs, 0);

    send(16'h24D5);
    chk("mov uop", uop, 6);
    chk("mov num", num, 213);
    chk("mov sel_in", sel_in, 4);
    send(16'h2BDC);
    chk("cmp uop", uop, 3);
    chk("cmp sel_p0", sel_p0, 3);
    chk("cmp num", num, 220);
    chk("cmp num_to_rhs", num_to_rhs, 1);
    chk("cmp sel_in", sel_in, 0);

    send(16'hE800);
    chk("undef explose", explose, 1);
    send(16'hE800);
    chk("undef count", illegal_count, 2);
    send(16'hE413);
    chk("b uop", uop, 9);
    chk("b num", num, 32'hFFFFFC13);
    @(posedge clk); #1;

    // back-pressure fills both entries
    out_ready = 1'b0; in_valid = 1'b1; instruction = 16'h6911;
    @(posedge clk); #1 instruction = 16'h65FE;
    @(posedge clk); #1 instruction = 16'h1A45;
    @(negedge clk);
    chk("bp in_ready", in_ready, 0);
    chk("ldr uop", uop, 7);
    chk("ldr sel_p0", sel_p0, 2);
    chk("ldr sel_in", sel_in, 1);
    chk("ldr num", num, 4);
    out_ready = 1'b1;
    @(negedge clk);
    chk("str uop", uop, 8);
    chk("str sel_p0", sel_p0, 7);
    chk("str sel_p1", sel_p1, 6);
    chk("str num", num, 23);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("sub uop", uop, 2);
    chk("sub sel_p0", sel_p0, 0);
    chk("sub sel_p1", sel_p1, 1);
    chk("sub sel_in", sel_in, 5);
    @(posedge clk); #1;

    // flush with two buffered entries and an undefined instruction offered
    out_ready = 1'b0; in_valid = 1'b1; instruction = 16'h24D5;
    @(posedge clk); #1 instruction = 16'h2BDC;
    @(posedge clk); #1 instruction = 16'hE800;
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush out_valid", out_valid, 0);
    chk("flush in_ready", in_ready, 1);
    chk("flush count", illegal_count, 2);
    in_valid = 1'b1; instruction = 16'hE800; flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush drop out_valid", out_valid, 0);
    chk("flush drop count", illegal_count, 2);

    out_ready = 1'b1;
    send(16'hD0FE);
`ifdef DECODE_BCOND_EN
    chk("bcc uop", uop, 10);
    chk("bcc cond", cond, 0);
    chk("bcc num", num, 32'hFFFFFFFE);
`else
    chk("bcc explose", explose, 1);
    chk("bcc cond", cond, 0);
`endif

    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      if (k == 1500) begin
        flush = 1'b0; in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midreset out_valid", out_valid, 0);
        chk("midreset in_ready", in_ready, 1);
        chk("midreset count", illegal_count, 0);
        chk("midreset num", num, 0);
        #3 rst_n = 1'b1;
      end else begin
        in_valid    = $urandom_range(0, 3) != 0;
        out_ready   = $urandom_range(0, 3) != 0;
        flush       = $urandom_range(0, 31) == 0;
        instruction = rand_ins();
      end
    end

    // saturation of the undefined-instruction counter
    flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1; instruction = 16'hE800;
    repeat (270) @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("saturated count", illegal_count, 8'hFF);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
